// File: rtl/lifo_drain_ctrl.sv
// Drains a burst (or all) of the LIFO stack and re-presents the words as a valid/ready stream.
// Optional LIFO_DRAIN_LAST_EN adds out_last marking the final word of the burst.
module lifo_drain_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] drained,
  output logic             lifo_hold,
  output logic             lifo_pop,
  input  logic             lifo_empty,
  input  logic [WIDTH-1:0] lifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LIFO_DRAIN_LAST_EN
  output logic             out_last,
`endif
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] remaining;
  logic             mode_all;
  logic             inflight;
  logic [1:0]       occ, occ_d;
  logic [2:0]       occ_sum;
  logic [WIDTH-1:0] slot1;
  logic             fire;
  logic             done_d;
  logic             start_acc;

  assign fire      = out_valid & out_ready;
  assign start_acc = (state == IDLE) & start;
  assign occ_sum   = 3'(occ) + 3'(inflight);
  assign lifo_hold = busy;

  // Next state, pop request and buffer occupancy
  always_comb begin
    state_d  = state;
    done_d   = 1'b0;
    lifo_pop = 1'b0;
    occ_d    = occ;
    case (state)
      IDLE: begin
        if (start) state_d = DRAIN;
      end
      DRAIN: begin
        lifo_pop = !lifo_empty && (mode_all || (remaining != '0)) &&
                   (occ_sum < (3'd2 + 3'(fire)));
        if ((!mode_all && (remaining == '0)) || (lifo_empty && !inflight))
          state_d = FLUSH;
      end
      FLUSH: begin
        if ((occ == 2'd0) && !inflight) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    case ({inflight, fire})
      2'b10:   occ_d = occ + 2'd1;
      2'b01:   occ_d = occ - 2'd1;
      default: occ_d = occ;
    endcase
  end

  // Control, counters and the 2-entry output buffer (out_data is the head slot)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      out_valid <= 1'b0;
      remaining <= '0;
      mode_all  <= 1'b0;
      drained   <= '0;
      out_data  <= '0;
      slot1     <= '0;
    end else begin
      state     <= state_d;
      busy      <= (state_d != IDLE);
      done      <= done_d;
      inflight  <= lifo_pop;
      occ       <= occ_d;
      out_valid <= (occ_d != 2'd0);

      if (start_acc) begin
        remaining <= len;
        mode_all  <= (len == '0);
      end else if (lifo_pop && !mode_all) begin
        remaining <= remaining - CNT_W'(1);
      end

      if (start_acc)
        drained <= '0;
      else if (fire && busy && (drained != '1))
        drained <= drained + CNT_W'(1);

      case ({inflight, fire})
        2'b10: begin
          if (occ == 2'd0) out_data <= lifo_dout;
          else             slot1    <= lifo_dout;
        end
        2'b01: out_data <= slot1;
        2'b11: begin
          if (occ == 2'd1) begin
            out_data <= lifo_dout;
          end else begin
            out_data <= slot1;
            slot1    <= lifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LIFO_DRAIN_LAST_EN
  logic last1;
  logic last_c;

  // A word is last when nothing more can be popped for this burst at its capture
  assign last_c = (!mode_all && (remaining == '0)) || lifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_last <= 1'b0;
      last1    <= 1'b0;
    end else begin
      case ({inflight, fire})
        2'b10: begin
          if (occ == 2'd0) out_last <= last_c;
          else             last1    <= last_c;
        end
        2'b01: out_last <= last1;
        2'b11: begin
          if (occ == 2'd1) begin
            out_last <= last_c;
          end else begin
            out_last <= last1;
            last1    <= last_c;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Scoreboard bench for lifo_drain_ctrl: a queue-based stack model feeds the DUT and a
// reference computes each burst's expected words, count and timing.
module tb_lifo_drain_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             busy, done, lifo_hold, lifo_pop, lifo_empty, out_valid;
  logic [CNT_W-1:0] drained;
  logic [WIDTH-1:0] lifo_dout = '0;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
`ifdef LIFO_DRAIN_LAST_EN
  logic             out_last;
`endif

  always #5 clk = ~clk;

  lifo_drain_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
    .busy(busy), .done(done), .drained(drained), .lifo_hold(lifo_hold),
    .lifo_pop(lifo_pop), .lifo_empty(lifo_empty), .lifo_dout(lifo_dout),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef LIFO_DRAIN_LAST_EN
    .out_last(out_last),
`endif
    .out_data(out_data)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] stk[$];
  int   stk_n = 0;
  exp_t exp_q[$];
  exp_t e;
  int   exp_drained, exp_left, exp_lat, exp_pops;
  bit   burst_active = 0;
  bit   done_seen = 0;
  int   ready_mode = 0;
  int   outstanding = 0;
  int   burst_pops = 0;
  int   ncyc = 0;
  int   start_ncyc = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stack model: registered read data, top of stack at the back of the queue
  assign lifo_empty = (stk_n == 0);
  always @(posedge clk) begin
    if (rstn && lifo_pop && (stk.size() != 0)) begin
      lifo_dout <= stk[$];
      stk.pop_back();
    end
    stk_n <= stk.size();
  end

  // Consumer ready pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and checks burst completion
  always @(negedge clk) begin
    ncyc++;
    if (!rstn) begin
      outstanding = 0;
      burst_pops  = 0;
    end else begin
      if (start) begin
        start_ncyc = ncyc;
        burst_pops = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
`ifdef LIFO_DRAIN_LAST_EN
          check("out_last", out_last, e.last);
`endif
        end
      end
      check("pop_when_empty", lifo_pop && lifo_empty, 0);
      if (lifo_pop) burst_pops++;
      outstanding = outstanding + (lifo_pop ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      check("buffer_bound", outstanding <= 2, 1);
      if (done) begin
        if (!burst_active) begin
          check("spurious_done", 1, 0);
        end else begin
          check("drained", drained, exp_drained);
          check("words_left_undelivered", exp_q.size(), 0);
          check("stack_left", stk.size(), exp_left);
          check("pop_count", burst_pops, exp_pops);
          if (exp_lat >= 0) check("done_latency", ncyc - start_ncyc, exp_lat);
          done_seen    = 1;
          burst_active = 0;
        end
      end
    end
  end

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) stk.push_back(WIDTH'($urandom));
  endtask

  // Reference: the top min(len, size) words in LIFO order (all when len == 0)
  task automatic run_burst(input int l, input int rmode, input bit stall);
    int sz, k;
    @(posedge clk);
    sz = stk.size();
    k  = (l == 0 || l > sz) ? sz : l;
    exp_q.delete();
    for (int i = 0; i < k; i++) exp_q.push_back('{data: stk[sz-1-i], last: (i == k-1)});
    exp_drained = (k > 15) ? 15 : k;
    exp_left    = sz - k;
    exp_pops    = k;
    exp_lat     = (rmode == 0 && !stall) ? ((k == 0) ? 3 : k + 4) : -1;
    done_seen    = 0;
    burst_active = 1;
    ready_mode   = rmode;
    @(posedge clk); #1;
    start = 1'b1;
    len   = CNT_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_in_burst", busy, 1);
    check("hold_eq_busy", lifo_hold, busy);
    if (stall) begin
      repeat (2) @(posedge clk);
      ready_mode = 2;
      repeat (5) @(posedge clk);
      ready_mode = rmode;
    end
    for (int t = 0; t < 400 && !done_seen; t++) @(posedge clk);
    if (!done_seen) begin
      check("done_timeout", 0, 1);
      burst_active = 0;
      exp_q.delete();
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pop", lifo_pop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_drained", drained, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Three known words, drain all at full rate
    stk.push_back(8'h11);
    stk.push_back(8'h22);
    stk.push_back(8'h33);
    run_burst(0, 0, 0);

    // Count mode shorter than the stack
    stk.delete();
    fill(5);
    run_burst(2, 0, 0);

    // Count mode longer than the stack
    stk.delete();
    fill(2);
    run_burst(6, 0, 0);

    // Backpressure in the middle of a burst
    stk.delete();
    fill(7);
    run_burst(0, 1, 1);

    // Empty stack
    stk.delete();
    run_burst(4, 0, 0);

    // Saturation of the drained count
    stk.delete();
    fill(18);
    run_burst(0, 0, 0);

    // Reset with two words buffered
    stk.delete();
    fill(5);
    exp_q.delete();
    burst_active = 1;
    ready_mode   = 2;
    @(posedge clk); #1;
    start = 1'b1;
    len   = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("full_before_reset", outstanding, 2);
    check("valid_before_reset", out_valid, 1);
    #2;
    rstn = 1'b0;
    burst_active = 0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pop", lifo_pop, 0);
    check("rst_mid_done", done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    run_burst(0, 0, 0);

    // Randomized bursts
    for (int r = 0; r < 12; r++) begin
      if (stk.size() > 10) stk.delete();
      fill($urandom_range(0, 6));
      run_burst($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_drain_ctrl.md
Name: lifo_drain_ctrl

Overview:
- Downstream consumer of the team's LIFO stack: issues pop requests, captures the popped word and re-presents it as a valid/ready stream.
- Used to unload a burst of N entries (or the whole stack) in LIFO order towards a packetiser or bus master.
- Handles the stack's one-cycle registered read latency internally with a 2-entry output buffer.
- Holds off upstream writers while a drain is in progress.

Parameters:
- WIDTH, 8, data width; must match the stack's WIDTH.
- CNT_W, 4, width of the burst-length command and the drained-count result.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command pulse; accepted only in IDLE.
- len  input  CNT_W  burst length sampled with start; 0 = drain until empty.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the burst is fully delivered.
- drained  output  CNT_W  number of words delivered in the last burst; valid from done onward.
- lifo_hold  output  1  equals busy; upstream must not push the stack while high.
- lifo_pop  output  1  pop request to the stack.
- lifo_empty  input  1  stack empty flag.
- lifo_dout  input  WIDTH  stack read data, valid the cycle after lifo_pop.
- out_valid  output  1  output word available.
- out_ready  input  1  consumer accepts; a transfer (fire) occurs when out_valid and out_ready are both high.
- out_data  output  WIDTH  output word, head of the buffer.

Behaviour:
- Reset (asynchronous, rstn low):
  - FSM goes to IDLE.
  - Buffer occupancy = 0; in-flight flag = 0.
  - busy, done, lifo_pop, out_valid = 0; out_data = 0; drained = 0; remaining counter = 0.
  - Reset mid-burst discards buffered and in-flight words; no done pulse is issued.
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE: start high → DRAIN. Load remaining = len, set mode_all = (len == 0), clear drained.
  - DRAIN → FLUSH when (not mode_all and remaining == 0) or (lifo_empty and in-flight == 0).
  - FLUSH: wait until occupancy == 0 and in-flight == 0, then pulse done for one cycle and return to IDLE.
  - start outside IDLE is ignored.
- Pop rule: lifo_pop = DRAIN and !lifo_empty and (mode_all or remaining != 0) and (occupancy + in-flight − fire) < 2.
  - lifo_pop is combinational, including from out_ready.
  - On each pop, in-flight is set for the following cycle and remaining decrements (count mode only).
- Capture: when in-flight is high, lifo_dout is written into the buffer at the end of that cycle. out_valid may rise on the next cycle.
- Latency: start to first lifo_pop is 1 cycle; pop to out_valid is 2 cycles.
- Throughput: with out_ready held high, one word per cycle is sustained.
- Buffer is a 2-entry FIFO with no overflow by construction. Simultaneous capture and fire keeps occupancy unchanged.
- Ordering: out_data order equals pop order, i.e. stack top first.
- drained increments on every fire while busy and saturates at all-ones.
- Short burst: if len exceeds the stack contents, the burst ends at empty and drained is less than len. This is not an error.
- Start with an empty stack: goes to DRAIN, then FLUSH, then done; drained = 0; no lifo_pop is ever asserted. Done pulses 3 cycles after start.

Optional Feature:
- Macro LIFO_DRAIN_LAST_EN.
- When defined: adds output out_last (1 bit), qualified by out_valid, which marks the final word of the burst.
  - A captured word is marked last if, in its capture cycle, (not mode_all and remaining == 0) or lifo_empty is high.
  - The bit is stored alongside the data in the buffer. Reset value 0.
- When undefined: the out_last port does not exist and behaviour is otherwise identical.

Test Plan:
- Stack holds 0x11,0x22,0x33 (0x33 on top), len=0, out_ready=1 → out_data 0x33,0x22,0x11 on consecutive cycles; done one cycle after the FLUSH exit condition is met; drained=3; out_last set on 0x11 only.
- Stack holds 5 words, len=2 → exactly 2 pops, the top two words are output, 3 words remain in the stack, drained=2.
- Stack holds 2 words, len=6 → stops at empty, drained=2, busy low after done.
- Backpressure: out_ready=0 for 5 cycles mid-burst → at most 2 words buffered, lifo_pop low while the buffer is full, no data lost or duplicated after out_ready returns to 1.
- Empty stack, len=4 → no lifo_pop, done pulses 3 cycles after start, drained=0.
- rstn asserted low mid-burst with 2 words buffered → out_valid, busy, lifo_pop = 0 immediately; no done; a new start after reset is accepted normally.
